// File: rtl/m72_pkg.sv
// Shared definitions for the M72 interrupt controller: port offsets, OCW2 codes,
// init sequencing states and the interrupt levels wired to video timing.
package m72_pkg;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [2:0] EOI_NONSPEC = 3'b001;
    localparam logic [2:0] EOI_SPEC    = 3'b011;

    localparam logic [2:0] VEC_VBLANK   = 3'd0;
    localparam logic [2:0] VEC_HINT     = 3'd2;
    localparam logic [2:0] VEC_SPURIOUS = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW4
    } init_state_t;

    // Vector byte replicated on both data lanes.
    function automatic logic [15:0] vec_word(input logic [4:0] base, input logic [2:0] lvl);
        return {2{base, lvl}};
    endfunction

endpackage

// File: rtl/m72_pic_prio_enc.sv
// Fixed-priority encoder: bit 0 is the highest priority.
module pic_prio_enc (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scanning downward lets the lowest set index overwrite any higher one.
        for (int unsigned i = 8; i > 0; i--) begin
            if (req[i-1]) begin
                idx = 3'(i - 1);
            end
        end
    end

endmodule

// File: rtl/m72_pic.sv
// 8259-subset interrupt controller answering the CPU's wishbone IO and INTA cycles.
module m72_pic
    import m72_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [7:0]  DEFAULT_BASE = 8'h20
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic        a1,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        ack,
    input  logic        inta,
    output logic        int_rq,
    input  logic [7:0]  irq_in
);

    logic [7:0]  irr, isr, imr, irq_prev;
    logic [4:0]  base;
    logic        aeoi, rd_isr, icw4_needed;
    init_state_t init_state;

    logic [7:0]  irr_n, isr_n, imr_n, irr_clr, edges;
    logic [4:0]  base_n;
    logic        aeoi_n, rd_isr_n, icw4_n;
    init_state_t init_n;
    logic [15:0] dout_n;

    logic [1:0]  cnt;
    logic        done, active, fire;

    logic        pend_valid, isr_valid;
    logic [2:0]  pend_idx, isr_idx;

    logic        unused_lanes;
    assign unused_lanes = ^{sel[1], din[15:8]};

    pic_prio_enc u_pend_enc (
        .req   (irr & ~imr),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    pic_prio_enc u_isr_enc (
        .req   (isr),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    assign edges  = irq_in & ~irq_prev;
    assign active = stb & (cs | inta);
    assign fire   = active & ~done & (cnt == WAIT_STATES[1:0]);

    // Bus handshake: one ack per strobe, after WAIT_STATES counted cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt  <= '0;
            done <= 1'b0;
            ack  <= 1'b0;
        end else begin
            ack <= fire;
            if (!stb) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (active && !done) begin
                if (cnt == WAIT_STATES[1:0]) begin
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    always_comb begin
        isr_n    = isr;
        imr_n    = imr;
        base_n   = base;
        aeoi_n   = aeoi;
        rd_isr_n = rd_isr;
        icw4_n   = icw4_needed;
        init_n   = init_state;
        dout_n   = dout;
        irr_clr  = '0;

        if (fire) begin
            if (inta) begin
                if (pend_valid) begin
                    dout_n            = vec_word(base, pend_idx);
                    irr_clr[pend_idx] = 1'b1;
                    if (!aeoi) begin
                        isr_n[pend_idx] = 1'b1;
                    end
                end else begin
                    dout_n = vec_word(base, VEC_SPURIOUS);
                end
            end else if (we) begin
                if (sel[0]) begin
                    if (a1 == PORT0) begin
                        if (din[4]) begin
                            imr_n  = '0;
                            isr_n  = '0;
                            icw4_n = din[0];
                            init_n = WAIT_ICW2;
                        end else if (din[4:3] == 2'b00) begin
                            if (din[6:5] == EOI_NONSPEC[1:0]) begin
                                if (isr_valid) begin
                                    isr_n[isr_idx] = 1'b0;
                                end
                            end else if (din[6:5] == EOI_SPEC[1:0]) begin
                                isr_n[din[2:0]] = 1'b0;
                            end
                        end else if (din[4:3] == 2'b01) begin
                            if (din[1]) begin
                                rd_isr_n = din[0];
                            end
                        end
                    end else begin
                        case (init_state)
                            WAIT_ICW2: begin
                                base_n = din[7:3];
                                init_n = icw4_needed ? WAIT_ICW4 : IDLE;
                            end
                            WAIT_ICW4: begin
                                aeoi_n = din[1];
                                init_n = IDLE;
                            end
                            default: imr_n = din[7:0];
                        endcase
                    end
                end
            end else begin
                dout_n = (a1 == PORT1) ? {2{imr}} : (rd_isr ? {2{isr}} : {2{irr}});
            end
        end

        // A new edge on the same clock as a clear leaves the request pending.
        irr_n = (irr & ~irr_clr) | edges;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irr         <= '0;
            isr         <= '0;
            imr         <= '0;
            base        <= DEFAULT_BASE[7:3];
            aeoi        <= 1'b0;
            rd_isr      <= 1'b0;
            icw4_needed <= 1'b0;
            init_state  <= IDLE;
            dout        <= '0;
            int_rq      <= 1'b0;
            irq_prev    <= irq_in;
        end else begin
            irr         <= irr_n;
            isr         <= isr_n;
            imr         <= imr_n;
            base        <= base_n;
            aeoi        <= aeoi_n;
            rd_isr      <= rd_isr_n;
            icw4_needed <= icw4_n;
            init_state  <= init_n;
            dout        <= dout_n;
            int_rq      <= pend_valid && (!isr_valid || (pend_idx < isr_idx));
            irq_prev    <= irq_in;
        end
    end

endmodule

// File: doc/m72_pic.md
Name: m72_pic

Overview:
- 8259/uPD71059-subset interrupt controller; wishbone responder to the zet CPU for both IO register access and interrupt-acknowledge (INTA) cycles.
- Replaces the ad-hoc vblank/hint trigger logic and the `pic` scratch register in the M72 top level.
- Latches edge-triggered requests (VBLK → level 0, HINT → level 2), raises `int_rq`, and returns the vector byte on INTA.
- Fixed priority, fully nested; EOI is either software (OCW2) or automatic.

Parameters:
- WAIT_STATES, 1, clock cycles `stb` is held before `ack`; legal range 0..3.
- DEFAULT_BASE, 8'h20, vector base after reset. Bits [2:0] are ignored. Gives vblank=0x20 and hint=0x22 without software init.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cs  in  1  INTCS decode; qualifies register access
- stb  in  1  wishbone strobe from the CPU
- we  in  1  write enable
- sel  in  2  byte lanes; only sel[0] is used for writes
- a1  in  1  cpu_addr[1]; 0 = port 0, 1 = port 1
- din  in  16  write data; low byte is used
- dout  out  16  read data / vector; byte replicated on both lanes
- ack  out  1  wishbone acknowledge
- inta  in  1  CPU tgc_o; marks an INTA cycle (cs not required)
- int_rq  out  1  interrupt request to the CPU tgc_i
- irq_in  in  8  raw request lines, level 0 = highest priority

Behaviour:
- Clock and reset: one clock (`clock`); reset is synchronous, active-low (`reset_n`).
- Reset values:
  - IRR=0, ISR=0, IMR=0, base=DEFAULT_BASE, aeoi=0, rd_isr=0, init_state=IDLE.
  - ack=0, dout=0, int_rq=0.
  - irq_in history = current irq_in, so no false edge is taken out of reset.
- Reset mid-cycle: a cycle in progress is abandoned and ack stays 0.
- Request capture:
  - A rising edge on irq_in[n] (registered previous vs current) sets IRR[n].
  - Levels are not re-armed until they fall.
- int_rq: registered. High iff some bit of (IRR & ~IMR) has lower index than the highest-priority set ISR bit (any index if ISR=0).
- Bus handshake:
  - A cycle is active when stb & (cs | inta).
  - Counter counts active cycles; ack=1 for exactly one clock once WAIT_STATES cycles have elapsed.
  - Counter clears when stb drops.
  - stb held after ack does not produce a second ack until stb drops.
  - All side effects occur on the ack clock only.
- INTA cycle (inta=1):
  - L = highest-priority pending unmasked level; dout = {base[7:3], L} in both bytes.
  - IRR[L] cleared; ISR[L] set unless aeoi=1.
  - No pending level (spurious): vector = {base[7:3], 3'd7]}, IRR/ISR unchanged.
  - Same-clock new edge on the level being acknowledged: set wins; IRR stays 1.
- Register writes (we=1, cs, sel[0]):
  - Port 0, din[4]=1 (ICW1): IMR=0, ISR=0, icw4_needed=din[0], init_state=WAIT_ICW2.
  - Port 1 in WAIT_ICW2: base=din[7:3]; next state is WAIT_ICW4 if icw4_needed, else IDLE.
  - Port 1 in WAIT_ICW4: aeoi=din[1]; next state IDLE.
  - Port 1 in IDLE (OCW1): IMR=din.
  - Port 0, din[4:3]=00 (OCW2):
    - din[5]=1, din[6]=0: non-specific EOI, clears the highest-priority set ISR bit.
    - din[6:5]=11: specific EOI, clears ISR[din[2:0]].
    - Other codes are ignored.
  - Port 0, din[4:3]=01 (OCW3): if din[1]=1 then rd_isr=din[0].
- Register reads:
  - Port 0 returns ISR if rd_isr, else IRR.
  - Port 1 returns IMR.
- Write-clear vs edge-set on the same clock: edge-set wins for IRR.
- Clears pending on the same clock as an INTA take effect before int_rq is re-evaluated next clock.

Decomposition:
- Shared package m72_pkg:
  - port offsets
  - OCW2 codes (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011)
  - init_state enum {IDLE, WAIT_ICW2, WAIT_ICW4}
  - VEC_VBLANK=0, VEC_HINT=2
- Sub-module pic_prio_enc: 8-bit fixed-priority encoder (valid + 3-bit index). Instantiated for IRR&~IMR and for ISR.

Test Plan:
1. Reset, pulse irq_in[0] → int_rq=1 within 2 clocks; INTA cycle → dout=16'h2020, ack after 1 wait; ISR=01, IRR=00, int_rq=0.
2. Edges on irq_in[2] and irq_in[0] in the same clock → first INTA vector 0x20. Write OCW2 0x20 → second INTA vector 0x22.
3. ICW1=0x13, ICW2=0x40, ICW4=0x03 (aeoi), edge irq_in[5] → INTA vector 0x45, ISR stays 0, back-to-back edge serviced immediately.
4. IMR=0x01 via port 1, edge irq_in[0] → int_rq stays 0, IRR read =0x01. IMR=0 → int_rq=1.
5. ISR[2] set, edge irq_in[4] → int_rq=0. Edge irq_in[1] → int_rq=1. Specific EOI 0x62 clears ISR[2].
6. INTA with nothing pending → vector 0x27, no state change. reset_n low during a held stb → ack never asserts, all registers at reset values.
